// File: rtl/inc_chain_pkg.sv
// inc_chain_pkg: command encodings, FSM states and op-decoding helpers for inc_chain_seq.
package inc_chain_pkg;
   typedef enum logic [1:0] {
      OP_POST_INC = 2'd0,
      OP_POST_DEC = 2'd1,
      OP_PRE_INC  = 2'd2,
      OP_PRE_DEC  = 2'd3
   } cmd_op_e;
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;
   function automatic logic op_is_dec(input cmd_op_e op);
      return (op == OP_POST_DEC) || (op == OP_PRE_DEC);
   endfunction
   function automatic logic op_is_pre(input cmd_op_e op);
      return (op == OP_PRE_INC) || (op == OP_PRE_DEC);
   endfunction
endpackage

// File: rtl/inc_chain_lane.sv
// inc_chain_lane: one channel register with +/-1 step, operand select and clamp flag.
// Saturating steps are enabled by defining INC_CHAIN_SATURATE_EN.
module inc_chain_lane
   import inc_chain_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             step_i,
   input  cmd_op_e          op_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] opnd_o,
   output logic             clamp_o
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   logic [WIDTH-1:0] r_q, r_d, step_val;
   logic dec, clamp;
   always_comb begin
      dec = op_is_dec(op_i);
`ifdef INC_CHAIN_SATURATE_EN
      clamp = dec ? (r_q == '0) : (&r_q);
`else
      clamp = 1'b0;
`endif
      step_val = clamp ? r_q : (dec ? r_q - ONE : r_q + ONE);
      r_d = load_i ? load_val_i : (step_i ? step_val : r_q);
      opnd_o = op_is_pre(op_i) ? step_val : r_q;
      clamp_o = clamp;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= '0;
      else     r_q <= r_d;
   end
   assign r_o = r_q;
endmodule

// File: rtl/inc_chain_seq.sv
// inc_chain_seq: multi-channel increment/decrement with a chained-sum result held in a 1-deep buffer.
// Saturating register steps are enabled by defining INC_CHAIN_SATURATE_EN.
module inc_chain_seq
   import inc_chain_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   input  logic [CHANNELS*WIDTH-1:0] load_data,
   input  logic                      cmd_valid,
   input  logic [1:0]                cmd_op,
   output logic                      cmd_ready,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [WIDTH-1:0]          res_sum,
   output logic [CHANNELS*WIDTH-1:0] res_opnd,
   output logic [CHANNELS*WIDTH-1:0] regs,
   output logic                      sat_hit
);
   state_e state_q;
   logic [CHANNELS-1:0][WIDTH-1:0] r_w, opnd_w, opnd_q;
   logic [CHANNELS-1:0] clamp_w;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic sat_d, sat_q, accept;
   cmd_op_e op;
   assign op        = cmd_op_e'(cmd_op);
   assign cmd_ready = !load_valid && (state_q == ST_EMPTY || res_ready);
   assign accept    = cmd_valid && cmd_ready;
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      inc_chain_lane #(.WIDTH(WIDTH)) u_lane (
         .clk        (clk),
         .rst        (rst),
         .load_i     (load_valid),
         .load_val_i (load_data[g*WIDTH +: WIDTH]),
         .step_i     (accept),
         .op_i       (op),
         .r_o        (r_w[g]),
         .opnd_o     (opnd_w[g]),
         .clamp_o    (clamp_w[g])
      );
   end
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < CHANNELS; i++) sum_d = sum_d + opnd_w[i];
      sat_d = |clamp_w;
   end
   // A simultaneous take and accept refills the buffer, so accept is tested first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         sum_q   <= '0;
         opnd_q  <= '0;
         sat_q   <= 1'b0;
      end else if (accept) begin
         state_q <= ST_FULL;
         sum_q   <= sum_d;
         opnd_q  <= opnd_w;
         sat_q   <= sat_d;
      end else if (res_ready) begin
         state_q <= ST_EMPTY;
      end
   end
   assign res_valid = (state_q == ST_FULL);
   assign res_sum   = sum_q;
   assign res_opnd  = opnd_q;
   assign sat_hit   = sat_q;
   assign regs      = r_w;
endmodule

// File: doc/inc_chain_seq.md
INC_CHAIN_SEQ -- requirements
Module: inc_chain_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bit width of each channel register.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning number of channel registers (legal range 1..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  load all channel registers this cycle.
REQ-006 SHALL have port load_data  input  CHANNELS*WIDTH  load values, channel 0 in LSBs.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_op  input  2  0 post-inc, 1 post-dec, 2 pre-inc, 3 pre-dec.
REQ-009 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-010 SHALL have port res_valid  output  1  result held.
REQ-011 SHALL have port res_ready  input  1  consumer takes result when res_valid && res_ready.
REQ-012 SHALL have port res_sum  output  WIDTH  chained-assignment result.
REQ-013 SHALL have port res_opnd  output  CHANNELS*WIDTH  per-channel operand values used.
REQ-014 SHALL have port regs  output  CHANNELS*WIDTH  current channel register contents.
REQ-015 SHALL have port sat_hit  output  1  saturation occurred on the held result.

Function
REQ-016 SHALL implement a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 SHALL drive cmd_ready = !load_valid && (EMPTY || res_ready).
REQ-018 SHALL, on accept, form operand v[i]: post ops use r[i]; pre ops use r[i] after the step.
REQ-019 SHALL update every r[i] by +1 (ops 0,2) or -1 (ops 1,3) on accept, modulo 2^WIDTH.
REQ-020 SHALL set res_sum = sum of all v[i] truncated to WIDTH; sum always wraps.
REQ-021 SHALL register res_sum/res_opnd/sat_hit with 1-cycle latency: accept at edge N, res_valid high after edge N.
REQ-022 SHALL hold res_* stable while FULL and !res_ready.
REQ-023 SHALL go FULL->EMPTY on res_ready with no accept; FULL->FULL with new data on simultaneous take and accept.
REQ-024 SHALL give load_valid priority: registers take load_data, no command accepted that cycle, held result unaffected.
REQ-025 SHALL expose regs combinationally from the channel registers.

Reset
REQ-026 SHALL, on rst assertion at any time, asynchronously clear all r[i], res_sum, res_opnd, sat_hit to 0 and enter EMPTY.
REQ-027 SHALL discard any held or in-flight result on reset; cmd_ready is 1 after release when load_valid=0.

Configuration
REQ-028 SHALL, with INC_CHAIN_SATURATE_EN defined, saturate register steps: +1 at all-ones stays all-ones, -1 at 0 stays 0; pre ops use the saturated value; sat_hit=1 if any channel clamped.
REQ-029 SHALL, without INC_CHAIN_SATURATE_EN, wrap per REQ-019 and tie sat_hit to 0.

Structure
REQ-030 SHALL place the cmd_op enum typedef and op encodings in package inc_chain_pkg.
REQ-031 SHALL use sub-module inc_chain_lane (one per channel: register, step, operand select, clamp flag).

Verification (WIDTH=4, CHANNELS=2)
REQ-032 SHALL cover: load {5,3}, op 0 -> res_sum 8, res_opnd {5,3}, regs {6,4} one cycle later.
REQ-033 SHALL cover: load {5,3}, op 2 -> res_sum A, res_opnd {6,4}, regs {6,4}.
REQ-034 SHALL cover: load {F,F}, op 0 -> res_sum E, regs {0,0}, sat_hit 0; with macro regs {F,F}, sat_hit 1.
REQ-035 SHALL cover: load {1,0}, op 3 -> res_sum F, res_opnd {0,F}; with macro res_opnd {0,0}, res_sum 0, sat_hit 1.
REQ-036 SHALL cover: res_ready=0, two cmds -> first held, cmd_ready=0 for second until res_ready pulses; load_valid with cmd_valid -> cmd not accepted.
REQ-037 SHALL cover: rst asserted mid-cycle while FULL -> res_valid, regs, res_sum at 0 immediately, no clock required.
